// File: rtl/rv32_branch_ctrl_pkg.sv
// Shared core types for the rv32 branch resolution path.
package rv32_branch_ctrl_pkg;

    typedef logic [31:0] rv32_word;

    typedef enum logic [2:0] {
        OP_BEQ  = 3'd0,
        OP_BNE  = 3'd1,
        OP_BLT  = 3'd2,
        OP_BGE  = 3'd3,
        OP_BLTU = 3'd4,
        OP_BGEU = 3'd5,
        OP_J    = 3'd6
    } branch_op_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2
    } bctrl_state_t;

    localparam logic [1:0] BHT_INIT = 2'b01;
    localparam rv32_word   PC_STEP  = 32'd4;

    // 2-bit saturating counter step
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        else
            return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/rv32_branch_ctrl_bht.sv
// Branch history table: 2-bit saturating counters, combinational read,
// read-before-write on a same-cycle update of the queried entry.
module rv32_bht
    import rv32_branch_ctrl_pkg::*;
#(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] ctr_q [ENTRIES];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < ENTRIES; i++)
                ctr_q[i] <= BHT_INIT;
        end else if (upd_en) begin
            ctr_q[upd_idx] <= sat_update(ctr_q[upd_idx], upd_taken);
        end
    end

    assign rd_taken = ctr_q[rd_idx][1];

endmodule

// File: rtl/rv32_branch_ctrl.sv
// Branch resolution controller: mispredict redirect/flush sequencing plus counters.
// Define RV_BRANCH_PRED_EN to include the BHT direction predictor; otherwise static not-taken.
module rv32_branch_ctrl
    import rv32_branch_ctrl_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES  = 64,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ex_valid,
    input  rv32_word   ex_pc,
    input  branch_op_t ex_branch_op,
    input  logic       ex_taken,
    input  rv32_word   ex_target,
    input  logic       ex_pred_taken,
    input  rv32_word   pred_pc,
    output logic       pred_taken,
    output logic       redirect_valid,
    output rv32_word   redirect_pc,
    input  logic       redirect_ready,
    output logic       flush_o,
    output rv32_word   br_count,
    output rv32_word   mispred_count
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);
    localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

    bctrl_state_t     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             resolve;
    logic             taken_eff;
    logic             mispredict;
    rv32_word         correct_pc;

    always_comb begin
        resolve    = ex_valid && (state_q == IDLE);
        taken_eff  = ex_taken || (ex_branch_op == OP_J);
        mispredict = resolve && (taken_eff != ex_pred_taken);
        correct_pc = taken_eff ? ex_target : ex_pc + PC_STEP;
    end

    // DRAIN holds for FLUSH_CYCLES-1 cycles after the handshake cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            redirect_pc <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mispredict) begin
                        state_q     <= REDIRECT;
                        redirect_pc <= correct_pc;
                    end
                end
                REDIRECT: begin
                    if (redirect_ready) begin
                        if (FLUSH_CYCLES == 1) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= DRAIN;
                            cnt_q   <= CNT_W'(FLUSH_CYCLES - 1);
                        end
                    end
                end
                DRAIN: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1))
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign redirect_valid = (state_q == REDIRECT);
    assign flush_o        = (state_q != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (resolve)
                br_count <= br_count + 32'd1;
            if (mispredict)
                mispred_count <= mispred_count + 32'd1;
        end
    end

`ifdef RV_BRANCH_PRED_EN
    logic bht_upd;
    logic unused_pc_bits;

    assign bht_upd        = resolve && (ex_branch_op != OP_J);
    assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};

    rv32_bht #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk       (clk),
        .rstn      (rstn),
        .rd_idx    (pred_pc[IDX_W+1:2]),
        .rd_taken  (pred_taken),
        .upd_en    (bht_upd),
        .upd_idx   (ex_pc[IDX_W+1:2]),
        .upd_taken (taken_eff)
    );
`else
    logic unused_pred_pc;

    assign unused_pred_pc = ^pred_pc;
    assign pred_taken     = 1'b0;
`endif

endmodule
